// File: rtl/sprite_fetch_seq_if.sv
// VRAM read port between the sprite fetch sequencer (master) and the VRAM
// arbiter/memory (slave). One read may be outstanding at a time.
//   vram_req   master -> slave  read request
//   vram_addr  master -> slave  byte address {tile-row word, plane}
//   vram_gnt   slave -> master  request accepted this cycle (with vram_req)
//   vram_valid slave -> master  read return strobe
//   vram_q     slave -> master  bank-0 byte
//   vram1_q    slave -> master  bank-1 byte
interface sprite_fetch_seq_if;
    logic        vram_req;
    logic [11:0] vram_addr;
    logic        vram_gnt;
    logic        vram_valid;
    logic [7:0]  vram_q;
    logic [7:0]  vram1_q;

    modport master (
        output vram_req, vram_addr,
        input  vram_gnt, vram_valid, vram_q, vram1_q
    );

    modport slave (
        input  vram_req, vram_addr,
        output vram_gnt, vram_valid, vram_q, vram1_q
    );
endinterface

// File: rtl/sprite_fetch_seq.sv
// Sprite tile-row fetch sequencer. After OAM sort, walks the sorted sprite
// slots 0..n-1 and reads the low and high bit-plane bytes of each sprite's
// tile row from VRAM, presenting each latched plane with a one-cycle strobe.
//
// Ports
//   clk, reset_n  clock, asynchronous active-low reset
//   start         one-cycle pulse beginning a line fetch (restarts if busy)
//   abort         cancels the fetch (line end / LCD off), beats everything
//   sprite_cnt    sprites on the line, sampled at start (clamped to MAX_FETCH)
//   bg_busy       background fetcher owns VRAM; suppresses vram_req
//   index         sorted-slot index presented to the sprite engine
//   spr_addr      tile-row word address for index from the sprite engine
//   vram          VRAM read port (master side)
//   data, data1   latched bank-0 / bank-1 bytes
//   dvalid        01 low plane latched, 10 high plane latched (one cycle)
//   busy, done    not idle / one-cycle completion pulse
//
// state   | meaning
// IDLE    | waiting for start
// REQ_LO  | requesting low plane byte of sprite index
// WAIT_LO | low plane read outstanding
// REQ_HI  | requesting high plane byte
// WAIT_HI | high plane read outstanding
// NEXT    | high plane presented; step index or finish
module sprite_fetch_seq #(
    parameter int MAX_FETCH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [3:0]            sprite_cnt,
    input  logic                  bg_busy,
    output logic [3:0]            index,
    input  logic [10:0]           spr_addr,
    sprite_fetch_seq_if.master    vram,
    output logic [7:0]            data,
    output logic [7:0]            data1,
    output logic [1:0]            dvalid,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ_LO  = 3'd1,
        S_WAIT_LO = 3'd2,
        S_REQ_HI  = 3'd3,
        S_WAIT_HI = 3'd4,
        S_NEXT    = 3'd5
    } state_t;

    localparam logic [3:0] MAX_N = 4'(MAX_FETCH);

    state_t     r_state;
    logic [3:0] r_index;
    logic [3:0] r_n;
    logic [7:0] r_data;
    logic [7:0] r_data1;
    logic [1:0] r_dvalid;
    logic       r_done;
    logic       r_drop;

    logic       w_req_st;
    logic       w_wait_st;
    logic       w_req;
    logic       w_accept;
    logic       w_take;
    logic       w_last;
    logic [3:0] w_n_new;

    assign w_req_st  = (r_state == S_REQ_LO) || (r_state == S_REQ_HI);
    assign w_wait_st = (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
    assign w_req     = w_req_st && !bg_busy;
    assign w_accept  = w_req && vram.vram_gnt;
    // A return that belongs to a cancelled read is swallowed, not latched.
    assign w_take    = w_wait_st && vram.vram_valid && !r_drop;
    assign w_last    = (r_index == (r_n - 4'd1));
    assign w_n_new   = (sprite_cnt > MAX_N) ? MAX_N : sprite_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_index  <= 4'd0;
            r_n      <= 4'd0;
            r_data   <= 8'd0;
            r_data1  <= 8'd0;
            r_dvalid <= 2'b00;
            r_done   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_dvalid <= 2'b00;
            r_done   <= 1'b0;
            if (vram.vram_valid) begin
                r_drop <= 1'b0;
            end

            if (abort) begin
                // A read left in flight must not be mistaken for the next one.
                if (w_wait_st && !vram.vram_valid) begin
                    r_drop <= 1'b1;
                end
                r_state <= S_IDLE;
            end else if (start) begin
                if (w_wait_st && !vram.vram_valid) begin
                    r_drop <= 1'b1;
                end
                r_index <= 4'd0;
                r_n     <= w_n_new;
                if (w_n_new == 4'd0) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= S_REQ_LO;
                end
            end else begin
                case (r_state)
                    S_REQ_LO: begin
                        if (w_accept) begin
                            r_state <= S_WAIT_LO;
                        end
                    end
                    S_WAIT_LO: begin
                        if (w_take) begin
                            r_data   <= vram.vram_q;
                            r_data1  <= vram.vram1_q;
                            r_dvalid <= 2'b01;
                            r_state  <= S_REQ_HI;
                        end
                    end
                    S_REQ_HI: begin
                        if (w_accept) begin
                            r_state <= S_WAIT_HI;
                        end
                    end
                    S_WAIT_HI: begin
                        if (w_take) begin
                            r_data   <= vram.vram_q;
                            r_data1  <= vram.vram1_q;
                            r_dvalid <= 2'b10;
                            // done shares the cycle with the final high-plane strobe
                            r_done   <= w_last;
                            r_state  <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_index <= r_index + 4'd1;
                            r_state <= S_REQ_LO;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign vram.vram_req  = w_req;
    assign vram.vram_addr = w_req_st ? {spr_addr, (r_state == S_REQ_HI)} : 12'd0;
    assign index          = r_index;
    assign data           = r_data;
    assign data1          = r_data1;
    assign dvalid         = r_dvalid;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;

endmodule

// File: tb/tb_sprite_fetch_seq.sv
module tb_sprite_fetch_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [3:0]  sprite_cnt;
    logic        bg_busy;
    logic [3:0]  index;
    logic [10:0] spr_addr;
    logic [7:0]  data;
    logic [7:0]  data1;
    logic [1:0]  dvalid;
    logic        busy;
    logic        done;

    sprite_fetch_seq_if vif();

    sprite_fetch_seq #(.MAX_FETCH(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .sprite_cnt (sprite_cnt),
        .bg_busy    (bg_busy),
        .index      (index),
        .spr_addr   (spr_addr),
        .vram       (vif),
        .data       (data),
        .data1      (data1),
        .dvalid     (dvalid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  dv;
        logic [3:0]  idx;
        logic [11:0] addr;
    } ev_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [10:0] spr_tab [16];
    logic [11:0] addr_q [$];
    ev_t         ev_q [$];
    bit          pend;
    int          pend_wait;
    logic [11:0] pend_addr;

    // VRAM contents as a fixed function of the byte address.
    function automatic logic [7:0] mem0(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem1(input logic [11:0] a);
        return a[10:3] + {a[2:0], a[11:7]} + 8'h33;
    endfunction

    function automatic int clamp_n(input logic [3:0] cnt);
        return (cnt > 4'd10) ? 10 : int'(cnt);
    endfunction

    task automatic rand_tab();
        for (int i = 0; i < 16; i++) spr_tab[i] = 11'($urandom);
    endtask

    // Expected line: for each sprite, low then high plane request/strobe.
    task automatic build_model(input logic [3:0] cnt, output int n);
        ev_t e;
        n = clamp_n(cnt);
        addr_q.delete();
        ev_q.delete();
        for (int i = 0; i < n; i++) begin
            addr_q.push_back({spr_tab[i], 1'b0});
            addr_q.push_back({spr_tab[i], 1'b1});
            e.dv = 2'b01; e.idx = 4'(i); e.addr = {spr_tab[i], 1'b0};
            ev_q.push_back(e);
            e.dv = 2'b10; e.idx = 4'(i); e.addr = {spr_tab[i], 1'b1};
            ev_q.push_back(e);
        end
    endtask

    task automatic quiet_inputs();
        start = 1'b0; abort = 1'b0; bg_busy = 1'b0; sprite_cnt = 4'd0;
        vif.vram_gnt = 1'b0; vif.vram_valid = 1'b0;
        vif.vram_q = 8'd0; vif.vram1_q = 8'd0;
        spr_addr = 11'd0;
    endtask

    // One line fetch driven cycle by cycle against the model.
    //   rnd        random gnt / bg_busy / read latency, else zero-wait
    //   bgb_from/len  forced bg_busy window (zero-wait mode)
    //   abort_at   cycle to assert abort (-1 none)
    //   restart_at cycle to re-issue start mid-fetch (-1 none)
    //   chain      number of new starts issued in done cycles
    task automatic run_fetch(input logic [3:0] cnt, input bit rnd,
                             input int bgb_from, input int bgb_len,
                             input int abort_at, input int restart_at,
                             input int chain);
        int  c, n_cur, exp_lat, chains_left, bgl;
        bit  finished, active, active_nxt, exp_done, lat_chk;
        logic [3:0] ncnt;
        ev_t e;
        pend = 1'b0;
        chains_left = chain;
        bgl = bgb_len;
        lat_chk = !rnd;
        finished = 1'b0;
        active = 1'b0;
        c = 0;
        @(negedge clk);
        build_model(cnt, n_cur);
        exp_lat = (n_cur == 0) ? 1 : 5 * n_cur + bgl;
        for (int cyc = 0; cyc < 1500 && !finished; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                c++;
            end
            start = (cyc == 0);
            sprite_cnt = cnt;
            abort = (abort_at >= 0 && cyc == abort_at);
            vif.vram_valid = 1'b0;
            vif.vram_q = 8'($urandom);
            vif.vram1_q = 8'($urandom);
            if (pend) begin
                if (pend_wait == 0) begin
                    vif.vram_valid = 1'b1;
                    vif.vram_q = mem0(pend_addr);
                    vif.vram1_q = mem1(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_wait--;
                end
            end
            bg_busy = rnd ? ($urandom_range(0, 4) == 0) : (c >= bgb_from && c < bgb_from + bgl);
            vif.vram_gnt = !pend && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            spr_addr = spr_tab[index];
            #1;
            active_nxt = active;
            if (abort_at >= 0 && cyc == abort_at + 1) begin
                vectors++;
                if (dvalid !== 2'b00 || done !== 1'b0 || busy !== 1'b0 || vif.vram_req !== 1'b0) begin
                    miscompares++;
                    $display("FAIL abort_idle: dvalid=%b done=%b busy=%b req=%b, required 00 0 0 0",
                             dvalid, done, busy, vif.vram_req);
                end
                finished = 1'b1;
            end else begin
                vectors++;
                if (vif.vram_req && bg_busy) begin
                    miscompares++;
                    $display("FAIL req_under_bg_busy: vram_req=1 with bg_busy=1 at cycle %0d", c);
                end
                if (vif.vram_req) begin
                    vectors++;
                    if (addr_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL req_addr: got request 0x%03h, required no request", vif.vram_addr);
                    end else if (vif.vram_addr !== addr_q[0]) begin
                        miscompares++;
                        $display("FAIL req_addr: got 0x%03h, required 0x%03h", vif.vram_addr, addr_q[0]);
                    end
                    if (vif.vram_gnt) begin
                        if (addr_q.size() != 0) void'(addr_q.pop_front());
                        pend = 1'b1;
                        pend_addr = vif.vram_addr;
                        pend_wait = rnd ? int'($urandom_range(0, 2)) : 0;
                    end
                end
                if (!rnd && bg_busy && addr_q.size() != 0) begin
                    vectors++;
                    if (vif.vram_req !== 1'b0 || vif.vram_addr !== addr_q[0]) begin
                        miscompares++;
                        $display("FAIL stall_addr: req=%b addr=0x%03h, required 0 0x%03h",
                                 vif.vram_req, vif.vram_addr, addr_q[0]);
                    end
                end
                exp_done = 1'b0;
                if (dvalid !== 2'b00) begin
                    vectors++;
                    if (ev_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL dvalid_extra: got dvalid=%b, required 00", dvalid);
                    end else begin
                        e = ev_q.pop_front();
                        if (dvalid !== e.dv || index !== e.idx || data !== mem0(e.addr) || data1 !== mem1(e.addr)) begin
                            miscompares++;
                            $display("FAIL plane: got dv=%b idx=%0d data=%02h data1=%02h, required dv=%b idx=%0d data=%02h data1=%02h",
                                     dvalid, index, data, data1, e.dv, e.idx, mem0(e.addr), mem1(e.addr));
                        end
                        if (ev_q.size() == 0) exp_done = 1'b1;
                    end
                end
                if (n_cur == 0 && c == 1) exp_done = 1'b1;
                vectors++;
                if (done !== exp_done) begin
                    miscompares++;
                    $display("FAIL done: got %b, required %b at cycle %0d", done, exp_done, c);
                end
                vectors++;
                if (busy !== active) begin
                    miscompares++;
                    $display("FAIL busy: got %b, required %b at cycle %0d", busy, active, c);
                end
                if (done) begin
                    if (lat_chk) begin
                        vectors++;
                        if (c != exp_lat) begin
                            miscompares++;
                            $display("FAIL latency: done at cycle %0d, required %0d", c, exp_lat);
                        end
                    end
                    active_nxt = 1'b0;
                    if (chains_left > 0) begin
                        chains_left--;
                        ncnt = 4'($urandom_range(1, 15));
                        rand_tab();
                        start = 1'b1;
                        sprite_cnt = ncnt;
                        cnt = ncnt;
                        build_model(ncnt, n_cur);
                        bgl = 0;
                        exp_lat = 5 * n_cur;
                        c = 0;
                        active_nxt = 1'b1;
                    end else begin
                        finished = 1'b1;
                    end
                end else if (restart_at >= 0 && cyc == restart_at) begin
                    ncnt = 4'($urandom_range(1, 15));
                    rand_tab();
                    start = 1'b1;
                    sprite_cnt = ncnt;
                    cnt = ncnt;
                    build_model(ncnt, n_cur);
                    lat_chk = 1'b0;
                    c = 0;
                    active_nxt = 1'b1;
                end
                if (cyc == 0 && n_cur > 0) active_nxt = 1'b1;
            end
            active = active_nxt;
        end
        if (!finished) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: fetch did not complete within cycle budget");
        end
        @(negedge clk);
        quiet_inputs();
        #1;
        vectors++;
        if (busy !== 1'b0 || vif.vram_req !== 1'b0 || dvalid !== 2'b00 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after: busy=%b req=%b dvalid=%b done=%b, required all 0",
                     busy, vif.vram_req, dvalid, done);
        end
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if (index !== 4'd0 || vif.vram_req !== 1'b0 || vif.vram_addr !== 12'd0 || data !== 8'd0 ||
            data1 !== 8'd0 || dvalid !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: idx=%0d req=%b addr=%03h data=%02h data1=%02h dv=%b busy=%b done=%b, required all 0",
                     tag, index, vif.vram_req, vif.vram_addr, data, data1, dvalid, busy, done);
        end
    endtask

    task automatic test_reset();
        quiet_inputs();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset_state");
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("after_release");
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) spr_tab[i] = 11'h123;
        run_fetch(4'd3, 1'b0, 0, 0, -1, -1, 0);
    endtask

    task automatic test_zero_cnt();
        rand_tab();
        run_fetch(4'd0, 1'b0, 0, 0, -1, -1, 0);
    endtask

    task automatic test_clamp();
        rand_tab();
        run_fetch(4'd15, 1'b0, 0, 0, -1, -1, 0);
    endtask

    task automatic test_bg_stall();
        rand_tab();
        run_fetch(4'd2, 1'b0, 1, 4, -1, -1, 0);
    endtask

    task automatic test_abort();
        rand_tab();
        run_fetch(4'd2, 1'b0, 0, 0, 4, -1, 0);
        rand_tab();
        run_fetch(4'd2, 1'b0, 0, 0, -1, -1, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            rand_tab();
            run_fetch(4'($urandom_range(0, 15)), 1'b1, 0, 0, -1, -1, int'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_restart();
        for (int k = 0; k < 5; k++) begin
            rand_tab();
            run_fetch(4'($urandom_range(2, 15)), 1'b1, 0, 0, -1, int'($urandom_range(3, 9)), 0);
        end
    endtask

    task automatic test_back_to_back();
        rand_tab();
        run_fetch(4'($urandom_range(1, 6)), 1'b0, 0, 0, -1, -1, 2);
    endtask

    task automatic test_reset_mid();
        rand_tab();
        quiet_inputs();
        @(negedge clk);
        start = 1'b1; sprite_cnt = 4'd2; spr_addr = spr_tab[0]; vif.vram_gnt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        vif.vram_gnt = 1'b0; vif.vram_valid = 1'b1;
        vif.vram_q = mem0({spr_tab[0], 1'b0}); vif.vram1_q = mem1({spr_tab[0], 1'b0});
        @(negedge clk);
        vif.vram_valid = 1'b0; vif.vram_gnt = 1'b1;
        #1;
        vectors++;
        if (vif.vram_req !== 1'b1 || vif.vram_addr !== {spr_tab[0], 1'b1}) begin
            miscompares++;
            $display("FAIL pre_reset_req_hi: req=%b addr=%03h, required 1 %03h",
                     vif.vram_req, vif.vram_addr, {spr_tab[0], 1'b1});
        end
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        vif.vram_gnt = 1'b0;
        reset_n = 1'b1;
        vif.vram_valid = 1'b1;
        @(negedge clk);
        vif.vram_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (dvalid !== 2'b00 || busy !== 1'b0 || vif.vram_req !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_idle: dvalid=%b busy=%b req=%b, required 00 0 0",
                         dvalid, busy, vif.vram_req);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_cnt();
        test_clamp();
        test_bg_stall();
        test_abort();
        test_random();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
